// File: rtl/block_dispatch_rr.sv
// Block dispatcher: splits a kernel into fixed-size thread blocks and hands them to cores round-robin.
// Optional macro DISPATCH_CYCLE_COUNT_EN adds a saturating kernel_cycles run-length counter.
module block_dispatch_rr #(
  parameter int NUM_CORES          = 2,
  parameter int THREADS_PER_BLOCK  = 4,
  parameter int THREAD_COUNT_WIDTH = 8
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic [THREAD_COUNT_WIDTH-1:0]                        thread_count,
  input  logic [NUM_CORES-1:0]                                 core_done,
  output logic [NUM_CORES-1:0]                                 core_start,
  output logic [NUM_CORES-1:0]                                 core_reset,
  output logic [NUM_CORES*THREAD_COUNT_WIDTH-1:0]              core_block_id,
  output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]   core_thread_count,
  output logic [THREAD_COUNT_WIDTH-1:0]                        blocks_done_count,
  output logic                                                 done
`ifdef DISPATCH_CYCLE_COUNT_EN
  ,
  output logic [31:0]                                          kernel_cycles
`endif
);

  localparam int TCW     = THREAD_COUNT_WIDTH;
  localparam int CTW     = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int TPB_LOG = $clog2(THREADS_PER_BLOCK);
  localparam int PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [CTW-1:0] TPB_VAL = CTW'(THREADS_PER_BLOCK);
  localparam logic [TCW:0]   ONE_B   = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state, state_d;
  logic [TCW:0]                   total_blocks, total_blocks_d;
  logic [TCW-1:0]                 tc_latched, tc_latched_d;
  logic [TCW:0]                   dispatched, dispatched_d;
  logic [PTR_W-1:0]               ptr, ptr_d;
  logic [NUM_CORES-1:0]           core_start_d, core_reset_d;
  logic [NUM_CORES*TCW-1:0]       core_block_id_d;
  logic [NUM_CORES*CTW-1:0]       core_thread_count_d;
  logic [TCW-1:0]                 blocks_done_d;
  logic                           done_d;

  int hi_idx, lo_idx, grant_idx, comp_cnt;

  // Wide enough that a full-scale thread count cannot overflow before the shift.
  function automatic logic [TCW:0] ceil_blocks(input logic [TCW-1:0] tc);
    return ({1'b0, tc} + (TCW+1)'(THREADS_PER_BLOCK - 1)) >> TPB_LOG;
  endfunction

  function automatic logic [CTW-1:0] last_threads(input logic [TCW-1:0] tc,
                                                  input logic [TCW:0]   disp);
    return CTW'({1'b0, tc} - (disp << TPB_LOG));
  endfunction

  // First free core at or after the pointer; otherwise wrap to the lowest free core.
  always_comb begin
    hi_idx = -1;
    lo_idx = -1;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_reset[i]) begin
        lo_idx = i;
        if (i >= int'(ptr)) hi_idx = i;
      end
    end
    grant_idx = (hi_idx >= 0) ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d             = state;
    total_blocks_d      = total_blocks;
    tc_latched_d        = tc_latched;
    dispatched_d        = dispatched;
    ptr_d               = ptr;
    core_start_d        = core_start;
    core_reset_d        = core_reset;
    core_block_id_d     = core_block_id;
    core_thread_count_d = core_thread_count;
    blocks_done_d       = blocks_done_count;
    done_d              = done;
    comp_cnt            = 0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d        = RUN;
          total_blocks_d = ceil_blocks(thread_count);
          tc_latched_d   = thread_count;
          dispatched_d   = '0;
          blocks_done_d  = '0;
          core_start_d   = '0;
          core_reset_d   = '1;
          done_d         = 1'b0;
        end
      end

      RUN: begin
        if (!start) begin
          state_d      = IDLE;
          core_start_d = '0;
          core_reset_d = '1;
          done_d       = 1'b0;
        end else if ({1'b0, blocks_done_count} == total_blocks) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (core_start[i] && core_done[i]) begin
              core_start_d[i] = 1'b0;
              core_reset_d[i] = 1'b1;
              comp_cnt        = comp_cnt + 1;
            end
          end
          blocks_done_d = blocks_done_count + TCW'(comp_cnt);

          // Eligibility uses the registered core_reset, so a core freed this cycle waits one edge.
          if ((dispatched < total_blocks) && (grant_idx >= 0)) begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (i == grant_idx) begin
                core_reset_d[i]                = 1'b0;
                core_start_d[i]                = 1'b1;
                core_block_id_d[i*TCW +: TCW]  = dispatched[TCW-1:0];
                core_thread_count_d[i*CTW +: CTW] =
                  (dispatched == total_blocks - ONE_B) ? last_threads(tc_latched, dispatched)
                                                       : TPB_VAL;
                ptr_d = PTR_W'((i + 1) % NUM_CORES);
              end
            end
            dispatched_d = dispatched + ONE_B;
          end
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      total_blocks      <= '0;
      tc_latched        <= '0;
      dispatched        <= '0;
      ptr               <= '0;
      core_start        <= '0;
      core_reset        <= '1;
      core_block_id     <= '0;
      core_thread_count <= {NUM_CORES{TPB_VAL}};
      blocks_done_count <= '0;
      done              <= 1'b0;
    end else begin
      state             <= state_d;
      total_blocks      <= total_blocks_d;
      tc_latched        <= tc_latched_d;
      dispatched        <= dispatched_d;
      ptr               <= ptr_d;
      core_start        <= core_start_d;
      core_reset        <= core_reset_d;
      core_block_id     <= core_block_id_d;
      core_thread_count <= core_thread_count_d;
      blocks_done_count <= blocks_done_d;
      done              <= done_d;
    end
  end

`ifdef DISPATCH_CYCLE_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      kernel_cycles <= '0;
    end else if (state == IDLE && start) begin
      kernel_cycles <= '0;
    end else if (state == RUN) begin
      kernel_cycles <= sat_inc(kernel_cycles);
    end
  end
`endif

endmodule
